// File: rtl/trace_canvas_gen.sv
// -----------------------------------------------------------------------------
// trace_canvas_gen
//
// Etch-A-Sketch canvas engine. It keeps a COLS x ROWS tile map in block RAM,
// with a COLOR_W-bit colour index per tile. Index 0 means an empty tile.
//
// The cursor moves from one-cycle step pulses. While trace_en is high,
// the current pen colour is painted under the cursor. A clear sweep writes 0
// to every tile. The engine also turns the sync generator's x/y into a
// registered RGB pixel.
//
// Optional build macro: CURSOR_BLINK_EN
//   Adds a free-running BLINK_LOG2-bit counter. The cursor overlay is shown
//   only while the counter MSB is 0. Painting is not affected.
//   Without the macro, the overlay is always shown.
//
// Ports
//   clk_100MHz        system clock
//   reset_n           asynchronous active-low reset
//   video_on          active display region from the VGA sync generator
//   x, y              current pixel coordinates (10 bits each)
//   step_l/r/u/d      one-cycle cursor step pulses
//   trace_en          paint pen_color at the cursor every IDLE cycle
//   pen_color         colour index written while tracing
//   clear_req         starts a clear sweep when the engine is idle
//   clear_busy        high for the whole sweep
//   cur_x, cur_y      cursor column / row
//   rgb               registered pixel colour, 2 clocks after x/y are sampled
// -----------------------------------------------------------------------------
module trace_canvas_gen #(
  parameter int          COLS        = 80,
  parameter int          ROWS        = 30,
  parameter int          TILE_W_LOG2 = 3,
  parameter int          TILE_H_LOG2 = 4,
  parameter int          COLOR_W     = 4,
  parameter int          START_X     = 35,
  parameter int          START_Y     = 15,
  parameter logic [11:0] CURSOR_RGB  = 12'hAAA,
  parameter int          BLINK_LOG2  = 24
) (
  input  logic               clk_100MHz,
  input  logic               reset_n,
  input  logic               video_on,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               step_l,
  input  logic               step_r,
  input  logic               step_u,
  input  logic               step_d,
  input  logic               trace_en,
  input  logic [COLOR_W-1:0] pen_color,
  input  logic               clear_req,
  output logic               clear_busy,
  output logic [6:0]         cur_x,
  output logic [4:0]         cur_y,
  output logic [11:0]        rgb
);

  localparam int          DEPTH    = COLS * ROWS;
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [10:0] CANVAS_W = 11'(COLS << TILE_W_LOG2);
  localparam logic [10:0] CANVAS_H = 11'(ROWS << TILE_H_LOG2);

  typedef enum logic [0:0] {S_IDLE, S_CLEAR} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     clr_addr_reg, clr_addr_next;
  logic [6:0]        cur_x_reg, cur_x_next;
  logic [4:0]        cur_y_reg, cur_y_next;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic [AW-1:0]     cursor_addr;

  // Tile RAM: one write port, one registered read port.
  logic [COLOR_W-1:0] tile_mem [DEPTH];
  logic [COLOR_W-1:0] rd_data_reg;

  // Pixel pipeline registers.
  logic              vid1_reg, off1_reg;
  logic [6:0]        col1_reg;
  logic [4:0]        row1_reg;
  logic [AW-1:0]     rd_addr_reg;
  logic              vid2_reg, off2_reg, hit2_reg;
  logic [11:0]       rgb_reg, rgb_next;

  logic              off_canvas;
  logic [6:0]        px_col;
  logic [4:0]        px_row;
  logic [AW-1:0]     px_addr;
  logic              overlay_en;

  // The address is linear (row*COLS + col), so the RAM holds only
  // COLS*ROWS entries instead of a power-of-two rectangle.
  assign cursor_addr = AW'(int'(cur_y_reg) * COLS + int'(cur_x_reg));

  // ---------------------------------------------------------------------------
  // Cursor / clear FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      clr_addr_reg <= '0;
      cur_x_reg    <= 7'(START_X);
      cur_y_reg    <= 5'(START_Y);
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
      cur_x_reg    <= cur_x_next;
      cur_y_reg    <= cur_y_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    cur_x_next    = cur_x_reg;
    cur_y_next    = cur_y_reg;
    wr_en         = 1'b0;
    wr_addr       = cursor_addr;
    wr_data       = pen_color;

    case (state_reg)
      S_IDLE: begin
        if (clear_req) begin
          state_next    = S_CLEAR;
          clr_addr_next = '0;
        end

        // Paint at the cursor position held before this edge.
        wr_en = trace_en;

        // Opposing pulses cancel each other out.
        if (step_r && !step_l)
          cur_x_next = (cur_x_reg == 7'(COLS - 1)) ? 7'd0 : cur_x_reg + 7'd1;
        else if (step_l && !step_r)
          cur_x_next = (cur_x_reg == 7'd0) ? 7'(COLS - 1) : cur_x_reg - 7'd1;

        if (step_d && !step_u)
          cur_y_next = (cur_y_reg == 5'(ROWS - 1)) ? 5'd0 : cur_y_reg + 5'd1;
        else if (step_u && !step_d)
          cur_y_next = (cur_y_reg == 5'd0) ? 5'(ROWS - 1) : cur_y_reg - 5'd1;
      end

      S_CLEAR: begin
        // The cursor holds, and step/trace/clear inputs are ignored.
        wr_en   = 1'b1;
        wr_addr = clr_addr_reg;
        wr_data = '0;
        if (clr_addr_reg == AW'(DEPTH - 1))
          state_next = S_IDLE;
        else
          clr_addr_next = clr_addr_reg + 1'b1;
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign clear_busy = (state_reg == S_CLEAR);
  assign cur_x      = cur_x_reg;
  assign cur_y      = cur_y_reg;

  // ---------------------------------------------------------------------------
  // Tile RAM. The read uses the old memory contents, so a read and a write
  // to the same address in one cycle return the old data (read-first).
  // It has no reset, so it maps onto block RAM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz) begin
    if (wr_en)
      tile_mem[wr_addr] <= wr_data;
    rd_data_reg <= tile_mem[rd_addr_reg];
  end

  // ---------------------------------------------------------------------------
  // Blink control for the cursor overlay
  // ---------------------------------------------------------------------------
`ifdef CURSOR_BLINK_EN
  logic [BLINK_LOG2-1:0] blink_reg;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n)
      blink_reg <= '0;
    else
      blink_reg <= blink_reg + 1'b1;
  end

  assign overlay_en = ~blink_reg[BLINK_LOG2-1];
`else
  // Overlay permanently on; BLINK_LOG2 only sizes the counter in the blink build.
  localparam logic OVERLAY_STATIC = (BLINK_LOG2 >= 0);
  assign overlay_en = OVERLAY_STATIC;
`endif

  // ---------------------------------------------------------------------------
  // Pixel pipeline. x/y are sampled at edge N. At edge N+1 the RAM data is
  // valid and the cursor match is registered. At edge N+2 rgb is registered.
  // ---------------------------------------------------------------------------
  assign off_canvas = ({1'b0, x} >= CANVAS_W) || ({1'b0, y} >= CANVAS_H);
  assign px_col     = x[TILE_W_LOG2 +: 7];
  assign px_row     = y[TILE_H_LOG2 +: 5];
  // Off-canvas coordinates would index past the map, so read tile 0 instead.
  // The colour mux masks that data anyway.
  assign px_addr    = off_canvas ? '0 : AW'(int'(px_row) * COLS + int'(px_col));

  function automatic logic [11:0] palette(input logic [COLOR_W-1:0] idx);
    logic [11:0] c;
    c = 12'h000;
    if (idx == COLOR_W'(0))      c = 12'hFFF;
    else if (idx == COLOR_W'(2)) c = 12'hF00;
    else if (idx == COLOR_W'(3)) c = 12'h0F0;
    else if (idx == COLOR_W'(4)) c = 12'h00F;
    return c;
  endfunction

  always_comb begin
    rgb_next = palette(rd_data_reg);
    if (!vid2_reg)
      rgb_next = 12'h000;
    else if (off2_reg)
      rgb_next = 12'hFFF;
    else if (hit2_reg)
      rgb_next = CURSOR_RGB;
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      vid1_reg    <= 1'b0;
      off1_reg    <= 1'b0;
      col1_reg    <= '0;
      row1_reg    <= '0;
      rd_addr_reg <= '0;
      vid2_reg    <= 1'b0;
      off2_reg    <= 1'b0;
      hit2_reg    <= 1'b0;
      rgb_reg     <= 12'h000;
    end else begin
      vid1_reg    <= video_on;
      off1_reg    <= off_canvas;
      col1_reg    <= px_col;
      row1_reg    <= px_row;
      rd_addr_reg <= px_addr;
      vid2_reg    <= vid1_reg;
      off2_reg    <= off1_reg;
      hit2_reg    <= overlay_en && (col1_reg == cur_x_reg) && (row1_reg == cur_y_reg);
      rgb_reg     <= rgb_next;
    end
  end

  assign rgb = rgb_reg;

endmodule
